// File: rtl/i2s_source_mux_pkg.sv
// Shared definitions for the frame-atomic I2S source multiplexer.
package i2s_source_mux_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int SYNC_CNT_W     = 8;

  typedef enum logic {
    PHASE_LEFT  = 1'b0,
    PHASE_RIGHT = 1'b1
  } phase_e;

  function automatic logic [SYNC_CNT_W-1:0] sat_inc(input logic [SYNC_CNT_W-1:0] v);
    if (v == {SYNC_CNT_W{1'b1}}) begin
      return v;
    end else begin
      return v + {{(SYNC_CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/i2s_source_mux_if.sv
// Source-side and transmitter-side AXI-stream bundle of the source multiplexer.
interface i2s_source_mux_if
  import i2s_source_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_SRC    = 4
);
  logic [NUM_SRC-1:0]            s_tvalid;
  logic [NUM_SRC*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_SRC-1:0]            s_tlast;
  logic [NUM_SRC-1:0]            s_tready;
  logic                          M_AXIS_TVALID;
  logic [DATA_WIDTH-1:0]         M_AXIS_TDATA;
  logic                          M_AXIS_TLAST;
  logic                          M_AXIS_TREADY;

  modport master (
    output s_tvalid, s_tdata, s_tlast, M_AXIS_TREADY,
    input  s_tready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );

  modport slave (
    input  s_tvalid, s_tdata, s_tlast, M_AXIS_TREADY,
    output s_tready, M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TLAST
  );
endinterface

// File: rtl/i2s_source_mux_frame_slot.sv
// Output register, L/R phase tracker and phase-mismatch drop counter.
module i2s_frame_slot
  import i2s_source_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  acc,
  input  logic [DATA_WIDTH-1:0] acc_data,
  input  logic                  acc_last,
  input  logic                  m_tready,
  output logic                  slot_free,
  output phase_e                phase,
  output logic                  m_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic [SYNC_CNT_W-1:0] sync_err_cnt
);

  phase_e                phase_q, phase_d;
  logic                  tvalid_q, tvalid_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tlast_q, tlast_d;
  logic [SYNC_CNT_W-1:0] cnt_q, cnt_d;
  logic                  load_s;

  assign slot_free = !tvalid_q || m_tready;

  // A word whose channel flag disagrees with the phase is swallowed so L/R never swap.
  always_comb begin
    load_s   = acc && (phase_e'(acc_last) == phase_q);
    phase_d  = phase_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    cnt_d    = cnt_q;
    if (load_s) begin
      tvalid_d = 1'b1;
      tdata_d  = acc_data;
      tlast_d  = acc_last;
      phase_d  = (phase_q == PHASE_LEFT) ? PHASE_RIGHT : PHASE_LEFT;
    end else if (tvalid_q && m_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
    if (acc && !load_s) begin
      cnt_d = sat_inc(cnt_q);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= PHASE_LEFT;
      tvalid_q <= 1'b0;
      tdata_q  <= {DATA_WIDTH{1'b0}};
      tlast_q  <= 1'b0;
      cnt_q    <= {SYNC_CNT_W{1'b0}};
    end else begin
      phase_q  <= phase_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      cnt_q    <= cnt_d;
    end
  end

  assign phase        = phase_q;
  assign m_tvalid     = tvalid_q;
  assign m_tdata      = tdata_q;
  assign m_tlast      = tlast_q;
  assign sync_err_cnt = cnt_q;

endmodule

// File: rtl/i2s_source_mux.sv
// Frame-atomic arbiter feeding one i2s_transmit stream from NUM_SRC stereo sources;
// source switches and mute changes take effect only at left-word boundaries.
module i2s_source_mux
  import i2s_source_mux_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int NUM_SRC    = 4,
  parameter int SEL_W      = $clog2(NUM_SRC),
  parameter bit DRAIN_IDLE = 1'b1
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  i2s_source_mux_if.slave       bus,
  input  logic                  sel_wr,
  input  logic [SEL_W-1:0]      sel_req,
  input  logic                  mute,
  output logic [SEL_W-1:0]      active_sel,
  output logic                  sel_pending,
  output logic                  sel_err,
  output logic [SYNC_CNT_W-1:0] sync_err_cnt
);

  logic                  run_q;
  logic [SEL_W-1:0]      active_sel_q, active_sel_d;
  logic [SEL_W-1:0]      pend_sel_q, pend_sel_d;
  logic                  pending_q, pending_d;
  logic                  sel_err_q, sel_err_d;
  logic                  muted_frame_q, muted_frame_d;

  logic                  slot_free_s;
  phase_e                phase_s;
  logic                  boundary_s, apply_s, mute_eff_s;
  logic                  act_ready_s, zero_ready_s;
  logic                  acc_s, acc_last_s;
  logic [DATA_WIDTH-1:0] acc_data_s;
  logic [NUM_SRC-1:0]    tready_s;

  // Mute is taken live at the left boundary, then frozen for the rest of the frame.
  always_comb begin
    boundary_s   = (phase_s == PHASE_LEFT) && slot_free_s;
    apply_s      = boundary_s && pending_q;
    mute_eff_s   = (phase_s == PHASE_LEFT) ? mute : muted_frame_q;
    act_ready_s  = run_q && slot_free_s && !mute_eff_s && !apply_s;
    zero_ready_s = run_q && slot_free_s && mute_eff_s && !apply_s;
    tready_s     = {NUM_SRC{1'b0}};
    acc_s        = 1'b0;
    acc_data_s   = {DATA_WIDTH{1'b0}};
    acc_last_s   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (active_sel_q == SEL_W'(i)) begin
        tready_s[i] = act_ready_s;
        if (!zero_ready_s) begin
          acc_s      = act_ready_s && bus.s_tvalid[i];
          acc_data_s = bus.s_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          acc_last_s = bus.s_tlast[i];
        end else begin
          acc_s      = 1'b1;
          acc_data_s = {DATA_WIDTH{1'b0}};
          acc_last_s = phase_s;
        end
      end else begin
        tready_s[i] = DRAIN_IDLE && run_q;
      end
    end
  end

  // A write landing on an applying boundary becomes the next pending request.
  always_comb begin
    active_sel_d  = active_sel_q;
    pend_sel_d    = pend_sel_q;
    pending_d     = pending_q;
    sel_err_d     = sel_err_q;
    muted_frame_d = muted_frame_q;
    if (apply_s) begin
      active_sel_d = pend_sel_q;
      pending_d    = 1'b0;
    end else begin
      active_sel_d = active_sel_q;
    end
    if (sel_wr) begin
      if (int'(sel_req) >= NUM_SRC) begin
        sel_err_d = 1'b1;
      end else begin
        sel_err_d = 1'b0;
        if (pending_d || (sel_req != active_sel_d)) begin
          pend_sel_d = sel_req;
          pending_d  = 1'b1;
        end else begin
          pend_sel_d = pend_sel_q;
        end
      end
    end else begin
      sel_err_d = sel_err_q;
    end
    if (acc_s && (phase_s == PHASE_LEFT) && !acc_last_s) begin
      muted_frame_d = mute_eff_s;
    end else begin
      muted_frame_d = muted_frame_q;
    end
  end

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      run_q         <= 1'b0;
      active_sel_q  <= {SEL_W{1'b0}};
      pend_sel_q    <= {SEL_W{1'b0}};
      pending_q     <= 1'b0;
      sel_err_q     <= 1'b0;
      muted_frame_q <= 1'b0;
    end else begin
      run_q         <= 1'b1;
      active_sel_q  <= active_sel_d;
      pend_sel_q    <= pend_sel_d;
      pending_q     <= pending_d;
      sel_err_q     <= sel_err_d;
      muted_frame_q <= muted_frame_d;
    end
  end

  i2s_frame_slot #(.DATA_WIDTH(DATA_WIDTH)) u_slot (
    .clk          (S_AXIS_ACLK),
    .rst_n        (S_AXIS_ARESETN),
    .acc          (acc_s),
    .acc_data     (acc_data_s),
    .acc_last     (acc_last_s),
    .m_tready     (bus.M_AXIS_TREADY),
    .slot_free    (slot_free_s),
    .phase        (phase_s),
    .m_tvalid     (bus.M_AXIS_TVALID),
    .m_tdata      (bus.M_AXIS_TDATA),
    .m_tlast      (bus.M_AXIS_TLAST),
    .sync_err_cnt (sync_err_cnt)
  );

  assign bus.s_tready = tready_s;
  assign active_sel   = active_sel_q;
  assign sel_pending  = pending_q;
  assign sel_err      = sel_err_q;

endmodule
